pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 29 ++
 rtl/pc_sequencer_target.sv | 35 +++
 rtl/pc_sequencer.sv | 154 +++++++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: next-PC operations and FSM states.
package pc_sequencer_pkg;

  // Next-PC operation as delivered by the EX stage.
  typedef enum logic [4:0] {
    NPC_PLUS4  = 5'd0,
    NPC_BRANCH = 5'd1,
    NPC_JUMP   = 5'd2,
    NPC_JALR   = 5'd3,
    NPC_MRET   = 5'd4
  } npc_op_e;

  // Sequencer FSM: normal fetch or killing younger stages after a redirect.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } seq_state_e;

  // True for every operation that replaces the sequential PC.
  function automatic logic is_redirect(input logic [4:0] op);
    logic r;
    case (op)
      NPC_BRANCH, NPC_JUMP, NPC_JALR, NPC_MRET: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_sequencer_target.sv
// pc_target_calc: combinational redirect-target selection and
// misalignment detection (bit 1 of a redirect target set).
module pc_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      npc_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] aluout,
  input  logic [XLEN-1:0] epc,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] target_s;

  // Select the redirect target; undefined operations fall back to sequential fetch.
  always_comb begin
    target_s = {XLEN{1'b0}};
    case (npc_op)
      NPC_BRANCH, NPC_JUMP: target_s = ex_pc + imm;
      NPC_JALR:             target_s = {aluout[XLEN-1:1], 1'b0};
      NPC_MRET:             target_s = epc;
      default:              target_s = {XLEN{1'b0}};
    endcase
  end

  assign redirect   = is_redirect(npc_op);
  assign target     = target_s;
  assign misaligned = redirect & target_s[1];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC register with trap/redirect/stall priority,
// a RUN/FLUSH state machine that kills younger stages, and a sticky
// misaligned-target fault with the offending address.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC     = 32'h0000_0100,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [4:0]      npc_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] aluout,
  input  logic [XLEN-1:0] epc,
  input  logic            exc,
  input  logic            fault_clr,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            mis_fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

  logic            redirect_s;
  logic            misaligned_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] next_pc_s;
  logic            event_s;
  logic            trap_mis_s;

  logic [XLEN-1:0] pc_r;
  logic            flush_r;
  logic            mis_fault_r;
  logic [XLEN-1:0] fault_pc_r;
  seq_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;

  pc_target_calc #(.XLEN(XLEN)) u_target (
    .npc_op     (npc_op),
    .ex_pc      (ex_pc),
    .imm        (imm),
    .aluout     (aluout),
    .epc        (epc),
    .redirect   (redirect_s),
    .target     (target_s),
    .misaligned (misaligned_s)
  );

  // Next-PC priority: exception, then redirect (trapping if misaligned), then stall, then +4.
  always_comb begin
    next_pc_s  = pc_r;
    event_s    = 1'b0;
    trap_mis_s = 1'b0;
    if (exc) begin
      next_pc_s = TRAP_VEC;
      event_s   = 1'b1;
    end else if (redirect_s) begin
      event_s = 1'b1;
      if (misaligned_s) begin
        next_pc_s  = TRAP_VEC;
        trap_mis_s = 1'b1;
      end else begin
        next_pc_s = target_s;
      end
    end else if (stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pc_r + PC_STEP;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_VEC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // RUN/FLUSH state machine; any new event restarts the flush window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      cnt_r   <= CNT_ZERO;
      flush_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (event_s) begin
            state_r <= ST_FLUSH;
            cnt_r   <= CNT_ZERO;
            flush_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
            flush_r <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (event_s) begin
            state_r <= ST_FLUSH;
            cnt_r   <= CNT_ZERO;
            flush_r <= 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
            flush_r <= 1'b0;
          end else begin
            state_r <= ST_FLUSH;
            cnt_r   <= cnt_r + CNT_ONE;
            flush_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_RUN;
          cnt_r   <= CNT_ZERO;
          flush_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky misaligned fault; a new trap beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_fault_r <= 1'b0;
      fault_pc_r  <= {XLEN{1'b0}};
    end else if (trap_mis_s) begin
      mis_fault_r <= 1'b1;
      fault_pc_r  <= target_s;
    end else if (fault_clr) begin
      mis_fault_r <= 1'b0;
    end else begin
      mis_fault_r <= mis_fault_r;
    end
  end

  assign pc        = pc_r;
  assign flush     = flush_r;
  assign mis_fault = mis_fault_r;
  assign fault_pc  = fault_pc_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          NFLUSH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [4:0]  npc_op = 5'd0;
  logic [31:0] ex_pc = 32'h0, imm = 32'h0, aluout = 32'h0, epc = 32'h0;
  logic        exc = 1'b0;
  logic        fault_clr = 1'b0;
  logic [31:0] pc, fault_pc;
  logic        flush, mis_fault;

  int checks = 0;
  int failures = 0;

  // Model state: expected outputs, flush expressed as remaining flush cycles.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fpc = 32'h0;
  logic        m_mis = 1'b0;
  int          m_rem = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op), .ex_pc(ex_pc),
    .imm(imm), .aluout(aluout), .epc(epc), .exc(exc), .fault_clr(fault_clr),
    .pc(pc), .flush(flush), .mis_fault(mis_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: decide the next PC from the rules, track flush as a countdown.
  always @(posedge clk or posedge rst) begin
    logic [31:0] tgt;
    logic        redir;
    logic        mtrap;
    if (rst) begin
      m_pc = RESET_VEC; m_rem = 0; m_mis = 1'b0; m_fpc = 32'h0;
    end else begin
      redir = 1'b1;
      tgt   = 32'h0;
      if (npc_op == 5'd1 || npc_op == 5'd2) tgt = ex_pc + imm;
      else if (npc_op == 5'd3) tgt = aluout & 32'hFFFF_FFFE;
      else if (npc_op == 5'd4) tgt = epc;
      else redir = 1'b0;
      mtrap = 1'b0;
      if (exc) begin
        m_pc = TRAP_VEC; m_rem = NFLUSH;
      end else if (redir) begin
        m_rem = NFLUSH;
        if ((tgt % 4) >= 2) begin
          m_pc = TRAP_VEC; m_mis = 1'b1; m_fpc = tgt; mtrap = 1'b1;
        end else begin
          m_pc = tgt;
        end
      end else begin
        if (!stall) m_pc = m_pc + 32'd4;
        if (m_rem > 0) m_rem = m_rem - 1;
      end
      if (fault_clr && !mtrap) m_mis = 1'b0;
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    chk("model_pc", pc, m_pc);
    chk("model_flush", {31'd0, flush}, {31'd0, (m_rem > 0)});
    chk("model_mis", {31'd0, mis_fault}, {31'd0, m_mis});
    chk("model_fpc", fault_pc, m_fpc);
  end

  // One cycle: apply inputs, wait for the next negedge, then settle.
  task automatic cyc(input logic [4:0] o, input logic s, input logic e, input logic fc,
                     input logic [31:0] xp, input logic [31:0] im, input logic [31:0] al,
                     input logic [31:0] ep);
    npc_op = o; stall = s; exc = e; fault_clr = fc;
    ex_pc = xp; imm = im; aluout = al; epc = ep;
    @(negedge clk); #2;
  endtask

  task automatic idle();
    cyc(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset state while rst is held
    repeat (2) @(negedge clk);
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_mis", {31'd0, mis_fault}, 32'd0);
    chk("rst_fpc", fault_pc, 32'h0);
    rst = 1'b0;

    // Idle fetch sequence from reset
    chk("idle_pc0", pc, 32'h0);
    idle(); chk("idle_pc1", pc, 32'h4); chk("idle_fl1", {31'd0, flush}, 32'd0);
    idle(); chk("idle_pc2", pc, 32'h8); chk("idle_fl2", {31'd0, flush}, 32'd0);
    idle(); chk("idle_pc3", pc, 32'hC); chk("idle_fl3", {31'd0, flush}, 32'd0);
    repeat (5) idle();
    chk("pc_at_20", pc, 32'h20);

    // Branch under stall, flush exactly two cycles
    cyc(5'd1, 1'b1, 1'b0, 1'b0, 32'h18, 32'h40, 32'h0, 32'h0);
    chk("br_pc", pc, 32'h58); chk("br_fl0", {31'd0, flush}, 32'd1);
    idle(); chk("br_pc1", pc, 32'h5C); chk("br_fl1", {31'd0, flush}, 32'd1);
    idle(); chk("br_pc2", pc, 32'h60); chk("br_fl2", {31'd0, flush}, 32'd0);

    // JALR clears bit 0; misaligned jump traps; fault_clr clears
    cyc(5'd3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1001, 32'h0);
    chk("jalr_pc", pc, 32'h1000); chk("jalr_mis", {31'd0, mis_fault}, 32'd0);
    cyc(5'd2, 1'b0, 1'b0, 1'b0, 32'h100, 32'h6, 32'h0, 32'h0);
    chk("mis_pc", pc, 32'h100); chk("mis_flag", {31'd0, mis_fault}, 32'd1);
    chk("mis_fpc", fault_pc, 32'h106);
    idle(); chk("mis_sticky", {31'd0, mis_fault}, 32'd1);
    cyc(5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("clr_mis", {31'd0, mis_fault}, 32'd0); chk("clr_fpc", fault_pc, 32'h106);
    repeat (3) idle();

    // Exception beats MRET; MRET during flush extends it
    cyc(5'd4, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h200);
    chk("exc_pc", pc, 32'h100); chk("exc_fl", {31'd0, flush}, 32'd1);
    cyc(5'd4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h200);
    chk("mret_pc", pc, 32'h200); chk("mret_fl0", {31'd0, flush}, 32'd1);
    idle(); chk("mret_fl1", {31'd0, flush}, 32'd1); chk("mret_pc1", pc, 32'h204);
    idle(); chk("mret_fl2", {31'd0, flush}, 32'd0);

    // Wrap from all-ones-minus-3 to zero
    cyc(5'd3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    idle(); chk("wrap_pc", pc, 32'h0);

    // Set and clear in the same cycle: set wins, new target captured
    cyc(5'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h42, 32'h0, 32'h0);
    chk("mis2_fpc", fault_pc, 32'h42);
    cyc(5'd3, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h7, 32'h0);
    chk("setwin_mis", {31'd0, mis_fault}, 32'd1); chk("setwin_fpc", fault_pc, 32'h6);
    chk("setwin_pc", pc, 32'h100); chk("setwin_fl", {31'd0, flush}, 32'd1);

    // Asynchronous reset mid-flush, no clock edge
    #1 rst = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0); chk("arst_fl", {31'd0, flush}, 32'd0);
    chk("arst_mis", {31'd0, mis_fault}, 32'd0); chk("arst_fpc", fault_pc, 32'h0);
    @(negedge clk); #2 rst = 1'b0;
    idle(); chk("post_rst_pc", pc, 32'h4); chk("post_rst_fl", {31'd0, flush}, 32'd0);
    cyc(5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("stall_hold", pc, 32'h4);

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 600; i++) begin
      logic [4:0] o;
      o = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(5, 31)) : 5'($urandom_range(0, 4));
      if ($urandom_range(0, 80) == 0) rst = 1'b1;
      cyc(o, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 7) == 0), $urandom, $urandom, $urandom, $urandom);
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
